// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op encodings, state enum and width for the multiply/divide sequencer
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX,
        S_DONE
    } mdu_state_t;

endpackage

// File: rtl/mdu_cneg.sv
// rtl/mdu_cneg.sv - conditional two's-complement negation, y = s ? -x : x
module mdu_cneg #(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    input  logic         s,
    output logic [W-1:0] y
);

    assign y = (x ^ {W{s}}) + {{(W-1){1'b0}}, s};

endmodule

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - 32-step shift-add multiply / restoring divide sequencer with HI/LO results
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_t       state, state_n;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] a_r, b_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] low_r;
    logic             sign_a, sign_b;
    logic [CW-1:0]    cnt;

    logic             is_div;
    logic             div_zero;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign is_div   = op_r[1];
    assign div_zero = is_div && (b_r == '0);
    assign a_neg    = op_r[0] & a_r[WIDTH-1];
    assign b_neg    = op_r[0] & b_r[WIDTH-1];

    mdu_cneg #(.W(WIDTH)) u_prep_a (.x(a_r), .s(a_neg), .y(a_mag));
    mdu_cneg #(.W(WIDTH)) u_prep_b (.x(b_r), .s(b_neg), .y(b_mag));

    // One WIDTH+1 adder serves both paths: carry-out for multiply, borrow for divide.
    logic [WIDTH:0] add_x, add_y, add_sum;
    logic           add_sub;

    always_comb begin
        add_x   = {1'b0, acc_r};
        add_y   = '0;
        add_sub = 1'b0;
        if (is_div) begin
            add_x   = {acc_r, low_r[WIDTH-1]};
            add_y   = {1'b0, b_r};
            add_sub = 1'b1;
        end else if (low_r[0]) begin
            add_y   = {1'b0, a_r};
        end
    end

    assign add_sum = add_x + (add_y ^ {(WIDTH+1){add_sub}}) + {{WIDTH{1'b0}}, add_sub};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    mdu_cneg #(.W(2*WIDTH)) u_fix_prod (.x({acc_r, low_r}), .s(sign_a ^ sign_b), .y(prod_fix));
    mdu_cneg #(.W(WIDTH))   u_fix_quo  (.x(low_r),          .s(sign_a ^ sign_b), .y(quo_fix));
    mdu_cneg #(.W(WIDTH))   u_fix_rem  (.x(acc_r),          .s(sign_a),          .y(rem_fix));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (start) state_n = S_PREP;
            S_PREP: state_n = div_zero ? S_DONE : S_RUN;
            S_RUN:  if (cnt == '0) state_n = S_FIX;
            S_FIX:  state_n = S_DONE;
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            op_r        <= '0;
            a_r         <= '0;
            b_r         <= '0;
            acc_r       <= '0;
            low_r       <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_r <= op;
                        a_r  <= a;
                        b_r  <= b;
                    end
                end
                S_PREP: begin
                    sign_a <= a_neg;
                    sign_b <= b_neg;
                    a_r    <= a_mag;
                    b_r    <= b_mag;
                    cnt    <= CW'(WIDTH - 1);
                    acc_r  <= '0;
                    low_r  <= is_div ? a_mag : b_mag;
                    // Divide by zero reports the original (unsigned-magnitude-free) dividend.
                    if (div_zero) begin
                        hi          <= a_r;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end
                end
                S_RUN: begin
                    cnt <= cnt - 1'b1;
                    if (is_div) begin
                        if (add_sum[WIDTH]) begin
                            acc_r <= add_x[WIDTH-1:0];
                            low_r <= {low_r[WIDTH-2:0], 1'b0};
                        end else begin
                            acc_r <= add_sum[WIDTH-1:0];
                            low_r <= {low_r[WIDTH-2:0], 1'b1};
                        end
                    end else begin
                        acc_r <= add_sum[WIDTH:1];
                        low_r <= {add_sum[0], low_r[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    div_by_zero <= 1'b0;
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - scoreboard bench for mdu_seq with directed and randomized requests
module tb_mdu_seq;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    mdu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   n_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Plain arithmetic reference; signed divide truncates toward zero like the ISA.
    function automatic void ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                      output logic [31:0] rh, output logic [31:0] rl, output logic rd);
        longint      sx, sy, p, r;
        logic [63:0] u;
        rd = 1'b0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o == OP_MULTU) begin
            u = {32'd0, x} * {32'd0, y};
        end else if (o == OP_MULT) begin
            p = sx * sy;
            u = p;
        end else if (y == 32'd0) begin
            u  = {x, 32'hFFFF_FFFF};
            rd = 1'b1;
        end else if (o == OP_DIVU) begin
            u = {x % y, x / y};
        end else begin
            p = sx / sy;
            r = sx % sy;
            u = {r[31:0], p[31:0]};
        end
        rh = u[63:32];
        rl = u[31:0];
    endfunction

    exp_t mon_e;
    always @(negedge clk) begin
        if (done) begin
            n_done++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending request (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("hi", 64'(hi), 64'(mon_e.hi));
                chk("lo", 64'(lo), 64'(mon_e.lo));
                chk("div_by_zero", 64'(div_by_zero), 64'(mon_e.dbz));
                chk("done_cycle", 64'(cyc - mon_e.acc + 1), 64'(mon_e.lat));
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el, input logic ed, input bit push);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=1 expected idle within 200 cycles");
        end
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (push) begin
            e.hi  = eh;
            e.lo  = el;
            e.dbz = ed;
            e.lat = (o[1] && y == 32'd0) ? 2 : 35;
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic issue_ref(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] rh, rl;
        logic        rd;
        ref_model(o, x, y, rh, rl, rd);
        issue(o, x, y, rh, rl, rd, 1'b1);
    endtask

    function automatic logic [31:0] pick_operand();
        int m;
        m = $urandom_range(0, 9);
        case (m)
            0:       return 32'd0;
            1:       return 32'($urandom_range(1, 15));
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int n;
        int dones_before;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        chk("reset_dbz", 64'(div_by_zero), 64'd0);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1);
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            chk($sformatf("busy_cycle%0d", k), 64'(busy), (k <= 35) ? 64'd1 : 64'd0);
        end

        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b1);
        issue(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b1);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b1);
        issue(OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b1);
        issue(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1'b1);
        issue(OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1'b1);

        // New requests and operand churn while busy must not disturb the accepted one.
        issue(OP_MULTU, 32'd1234, 32'd5678, 32'd0, 32'd7006652, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        for (int k = 0; k < 15; k++) begin
            start = 1'b1;
            op    = OP_DIV;
            a     = $urandom;
            b     = $urandom;
            @(negedge clk);
        end
        start = 1'b0;

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        dones_before = n_done;

        // Abort in the tenth RUN cycle; the request is never scored.
        issue(OP_MULTU, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        repeat (50) @(negedge clk);
        chk("abort_no_done", 64'(n_done), 64'(dones_before));

        issue(OP_DIVU, 32'd1000, 32'd33, 32'd10, 32'd30, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            issue_ref(2'($urandom_range(0, 3)), pick_operand(), pick_operand());
        end

        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Multi-cycle multiply/divide sequencer for the CPU's ALU cluster. It accepts MULT, MULTU, DIV and DIVU requests from the execute stage and iterates a single shared 32-bit add/subtract datapath over 32 cycles. It produces HI/LO results with a start/busy/done handshake, so the pipeline stalls on `busy`.

## Interface
Parameters:
- `WIDTH`, 32: operand width; iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request strobe; sampled only in IDLE.
- `op`  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a`  in  32  multiplicand or dividend (rs).
- `b`  in  32  multiplier or divisor (rt).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid from this cycle on.
- `hi`  out  32  product[63:32], or remainder.
- `lo`  out  32  product[31:0], or quotient.
- `div_by_zero`  out  1  updated with each `done`; high when a DIV/DIVU had `b == 0`.

## Operation
- States: IDLE, PREP, RUN, FIX, DONE.
- **IDLE:** `start=1` latches `op`, `a`, `b` and moves to PREP. `start=0` stays in IDLE. Input changes while busy are ignored.
- **PREP:**
  - Signed ops (01, 11) record each operand's sign and replace each operand with its magnitude.
  - Unsigned ops pass operands unchanged.
  - A divide with `b == 0` goes directly to DONE. Otherwise, load `cnt = WIDTH-1` and go to RUN.
- **RUN, multiply:** shift-add. If the product LSB is 1, add the multiplicand to the upper half. Then shift the {carry, upper, lower} register right by 1.
- **RUN, divide:** restoring division. Shift {rem, quo} left by 1 and trial-subtract the divisor from `rem`. If there is no borrow, keep the difference and set the quotient LSB to 1. Otherwise restore and set the quotient LSB to 0.
- **RUN exit:** `cnt` decrements each cycle. When `cnt == 0`, go to FIX.
- **FIX:**
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; negate the remainder if the dividend is negative.
  - Register the results into `hi`/`lo`, then go to DONE.
- **DONE:** `done=1` for one cycle, then return to IDLE. `start` is ignored in DONE; a new request is accepted the following cycle.
- **Divide by zero:** `hi = a` (latched), `lo = 32'hFFFF_FFFF`, `div_by_zero = 1`. On any other completion, `div_by_zero = 0`.
- **Signed overflow:** `0x8000_0000 / 0xFFFF_FFFF` yields `lo = 0x8000_0000`, `hi = 0`. This is the natural two's-complement wrap; it is not flagged.
- **Result hold:** `hi`/`lo`/`div_by_zero` hold their last values until the next DONE.

## Timing
- **Reset values:** state IDLE; `busy=0`, `done=0`, `hi=0`, `lo=0`, `div_by_zero=0`, `cnt=0`.
- **Reset priority:** `rst` overrides every state. Reset mid-operation aborts with no `done`, and the partial result is discarded.
- **Normal latency:** `start` is accepted at edge 0.
  - PREP in cycle 1.
  - RUN in cycles 2–33.
  - FIX in cycle 34.
  - `done` in cycle 35.
- **Divide-by-zero latency:** `done` in cycle 2.
- **busy:** rises in the cycle after acceptance and falls in the cycle after `done`.
- **Back-to-back:** the earliest next accepted `start` is in the cycle after DONE.
- **Result visibility:** `hi`/`lo` change only on the edge entering DONE.

## Structure
- **Package `mdu_pkg`:**
  - op encodings `OP_MULTU`, `OP_MULT`, `OP_DIVU`, `OP_DIV`;
  - the state enum;
  - `MDU_WIDTH = 32`.
- **Sub-module `mdu_cneg`** (parameter `W`): conditional two's-complement negation, `y = (x ^ {W{s}}) + s`. It is instantiated at W=32 in PREP and at W=64 / W=32 in FIX.
- **Shared adder:** a single `WIDTH+1`-bit adder/subtractor is time-shared between the multiply and divide paths. No second adder is permitted.

## Test plan
- MULTU `0xFFFF_FFFF * 0xFFFF_FFFF` → `hi=0xFFFF_FFFE`, `lo=0x0000_0001`; `done` exactly 35 cycles after the accepting edge; `busy` high cycles 1–35.
- MULT `-3 * 7` → `hi=0xFFFF_FFFF`, `lo=0xFFFF_FFEB`; DIVU `100 / 7` → `lo=14`, `hi=2`.
- DIV `-7 / 2` → `lo=0xFFFF_FFFD`, `hi=0xFFFF_FFFF`; DIV `0x8000_0000 / 0xFFFF_FFFF` → `lo=0x8000_0000`, `hi=0`, `div_by_zero=0`.
- DIVU `5 / 0` → `done` in cycle 2, `div_by_zero=1`, `hi=5`, `lo=0xFFFF_FFFF`. A following MULTU `2*3` clears `div_by_zero` and gives `lo=6`.
- Drive `start=1` with new operands during RUN, and change `a`/`b` during RUN → the result reflects only the first request; no extra `done`.
- Assert `rst` in RUN cycle 10 → next cycle `busy=0`, `hi=lo=0`, and no `done` ever appears. A fresh `start` afterwards completes normally.
